// File: rtl/ifa_arb_pkg.sv
// Shared types for the ifa bus arbiter: FSM state encoding and bus mode type.
package ifa_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    REQ   = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } arb_state_e;

  typedef logic [1:0] ifa_mode_t;

  localparam ifa_mode_t MODE_READ = 2'b00;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [PW-1:0]   o_winner,
  output logic            o_valid
);

  logic [PW-1:0] w_idx;

  // Scan from farthest to nearest so the nearest asserted request overwrites last.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a path with no
    // assignment would hold its old value and infer a latch.
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = PW'((int'(i_ptr) + i) % NREQ);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifa_bus_arbiter.sv
// Round-robin arbiter sharing one ifa read bus among NREQ requesters; one read per grant,
// returning read data or a timeout error to the winner.
module ifa_bus_arbiter
  import ifa_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_i,
  input  logic [2*NREQ-1:0] mode_i,
  input  logic [NREQ*AW-1:0] addr_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic              err_o,
  output logic [DW-1:0]     rdata_o,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_start,
  output logic [1:0]        bus_mode,
  output logic [AW-1:0]     bus_addr,
  input  logic              bus_rdy,
  input  logic [DW-1:0]     bus_data
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  // Count value seen during the last permitted WAIT cycle.
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT - 1);

  arb_state_e      r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_winner;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic            r_err;
  logic [DW-1:0]   r_rdata;
  logic            r_bus_req;
  logic            r_bus_start;
  ifa_mode_t       r_mode;
  logic [AW-1:0]   r_addr;
  logic [CW-1:0]   r_cnt;

  logic [PW-1:0]   w_winner;
  logic            w_valid;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .i_req    (req_i),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_valid  (w_valid)
  );

  // NOTE: all state here uses non-blocking assignments so every register samples the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_winner    <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_bus_req   <= 1'b0;
      r_bus_start <= 1'b0;
      r_mode      <= MODE_READ;
      r_addr      <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: if (|req_i) r_state <= ARB;
        ARB: begin
          if (w_valid) begin
            r_winner  <= w_winner;
            r_gnt     <= NREQ'(1) << w_winner;
            r_mode    <= mode_i[2*w_winner +: 2];
            r_addr    <= addr_i[AW*w_winner +: AW];
            r_bus_req <= 1'b1;
            r_state   <= REQ;
          end else begin
            r_state <= IDLE;
          end
        end
        REQ: begin
          if (bus_gnt) begin
            r_bus_start <= 1'b1;
            r_state     <= START;
          end
        end
        START: begin
          r_bus_start <= 1'b0;
          r_cnt       <= '0;
          r_state     <= WAIT;
        end
        WAIT: begin
          // Slave data takes priority over a timeout landing in the same cycle.
          if (bus_rdy) begin
            r_rdata <= bus_data;
            r_err   <= 1'b0;
            r_done  <= r_gnt;
            r_state <= DONE;
          end else if (r_cnt == TERM) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_done  <= r_gnt;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_done    <= '0;
          r_err     <= 1'b0;
          r_rdata   <= '0;
          r_gnt     <= '0;
          r_bus_req <= 1'b0;
          r_mode    <= MODE_READ;
          r_addr    <= '0;
          r_ptr     <= (r_winner == PW'(NREQ - 1)) ? '0 : r_winner + 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt_o     = r_gnt;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign rdata_o   = r_rdata;
  assign bus_req   = r_bus_req;
  assign bus_start = r_bus_start;
  assign bus_mode  = r_mode;
  assign bus_addr  = r_addr;

endmodule

// File: tb/tb_ifa_bus_arbiter.sv
// Randomized scoreboard bench for ifa_bus_arbiter with a behavioural slave and a
// round-robin reference model computed from request distances to the pointer.
module tb_ifa_bus_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b1;
  logic [NREQ-1:0]   req_i  = '0;
  logic [2*NREQ-1:0] mode_i = '0;
  logic [NREQ*AW-1:0] addr_i = '0;
  logic [NREQ-1:0]   gnt_o;
  logic [NREQ-1:0]   done_o;
  logic              err_o;
  logic [DW-1:0]     rdata_o;
  logic              bus_req;
  logic              bus_gnt  = 1'b0;
  logic              bus_start;
  logic [1:0]        bus_mode;
  logic [AW-1:0]     bus_addr;
  logic              bus_rdy  = 1'b0;
  logic [DW-1:0]     bus_data = '0;

  ifa_bus_arbiter #(
    .NREQ    (NREQ),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .mode_i    (mode_i),
    .addr_i    (addr_i),
    .gnt_o     (gnt_o),
    .done_o    (done_o),
    .err_o     (err_o),
    .rdata_o   (rdata_o),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .bus_start (bus_start),
    .bus_mode  (bus_mode),
    .bus_addr  (bus_addr),
    .bus_rdy   (bus_rdy),
    .bus_data  (bus_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              idx;
    logic [AW-1:0]   addr;
    logic [1:0]      mode;
    logic [DW-1:0]   data;
    logic            err;
    int              lat;
    int              t_issue;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_ptr    = 0;

  int            cfg_gnt_delay = 0;
  int            cfg_rdy_delay = 1;
  logic [DW-1:0] cfg_data      = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Winner = asserted requester with the smallest forward distance from the pointer.
  function automatic int model_pick(input logic [NREQ-1:0] req, input int ptr);
    int best, best_d, d;
    best   = -1;
    best_d = NREQ;
    for (int k = 0; k < NREQ; k++) begin
      d = (k - ptr + NREQ) % NREQ;
      if (req[k] && d < best_d) begin
        best_d = d;
        best   = k;
      end
    end
    return best;
  endfunction

  // Behavioural slave: grants after cfg_gnt_delay REQ cycles, answers in WAIT cycle
  // number cfg_rdy_delay after the start strobe (0 = never).
  initial begin : slave
    int   gcnt, wcnt, phase;
    logic gnt_prev;
    gcnt = 0; wcnt = 0; phase = 0; gnt_prev = 1'b0;
    forever begin
      @(posedge clk); #1;
      gnt_prev = bus_gnt;
      bus_gnt  = 1'b0;
      bus_rdy  = 1'b0;
      bus_data = DW'($urandom);
      if (!bus_req) begin
        phase = 0;
        gcnt  = 0;
      end else if (bus_start) begin
        check("start_after_gnt", gnt_prev, 1);
        phase = 1;
        wcnt  = 0;
      end else if (phase == 0) begin
        if (gcnt >= cfg_gnt_delay) bus_gnt = 1'b1;
        gcnt++;
      end else if (phase == 1) begin
        wcnt++;
        if (wcnt == cfg_rdy_delay) begin
          bus_rdy  = 1'b1;
          bus_data = cfg_data;
          phase    = 2;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      check("gnt_onehot0", $onehot0(gnt_o), 1);
      if (gnt_o == '0) begin
        check("idle_bus_req", bus_req, 0);
        check("idle_bus_start", bus_start, 0);
        check("idle_bus_addr", bus_addr, 0);
        check("idle_bus_mode", bus_mode, 0);
      end else if (sb.size() == 0) begin
        check("gnt_unexpected", gnt_o, 0);
      end else begin
        check("gnt_winner", gnt_o, onehot(sb[0].idx));
        check("bus_req_held", bus_req, 1);
        check("bus_addr", bus_addr, sb[0].addr);
        check("bus_mode", bus_mode, sb[0].mode);
      end
      if (done_o != '0) begin
        if (sb.size() == 0) begin
          check("done_unexpected", done_o, 0);
        end else begin
          e = sb.pop_front();
          check("done_vec", done_o, onehot(e.idx));
          check("err", err_o, e.err);
          check("rdata", rdata_o, e.data);
          check("latency", cyc - e.t_issue, e.lat);
        end
      end else begin
        check("err_without_done", err_o, 0);
      end
    end
  end

  task automatic randomize_inputs(input int addr_ovr);
    for (int i = 0; i < NREQ; i++) begin
      addr_i[AW*i +: AW] = (addr_ovr >= 0) ? AW'(addr_ovr) : AW'($urandom);
      mode_i[2*i +: 2]   = 2'($urandom);
    end
  endtask

  task automatic wait_done(input bit scramble);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(posedge clk); #1;
      if (done_o != '0) seen = 1'b1;
      else if (scramble && gnt_o != '0) begin
        req_i = NREQ'($urandom);
        randomize_inputs(-1);
      end
    end
    check("done_seen", seen, 1);
    if (!seen) sb.delete();
  endtask

  // Issue right after a done pulse (gap 0) or after gap idle cycles with req low.
  task automatic issue(input logic [NREQ-1:0] req, input int gd, input int rd,
                       input logic [DW-1:0] data, input int gap, input int addr_ovr);
    int   base, w, wc;
    bit   ok;
    exp_t e;
    if (gap > 0) begin
      req_i = '0;
      repeat (gap) begin @(posedge clk); #1; end
      base = 4;
    end else begin
      base = 5;
    end
    randomize_inputs(addr_ovr);
    cfg_gnt_delay = gd;
    cfg_rdy_delay = rd;
    cfg_data      = data;
    w  = model_pick(req, m_ptr);
    ok = (rd >= 1 && rd <= TIMEOUT);
    wc = ok ? rd : TIMEOUT;
    e.idx     = w;
    e.addr    = addr_i[AW*w +: AW];
    e.mode    = mode_i[2*w +: 2];
    e.err     = !ok;
    e.data    = ok ? data : '0;
    e.lat     = base + gd + wc;
    e.t_issue = cyc;
    sb.push_back(e);
    m_ptr = (w + 1) % NREQ;
    req_i = req;
  endtask

  task automatic txn(input logic [NREQ-1:0] req, input int gd, input int rd,
                     input logic [DW-1:0] data, input int gap, input bit scramble,
                     input int addr_ovr);
    issue(req, gd, rd, data, gap, addr_ovr);
    wait_done(scramble);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_rdata"}, rdata_o, 0);
    check({tag, "_bus_req"}, bus_req, 0);
    check({tag, "_bus_start"}, bus_start, 0);
    check({tag, "_bus_addr"}, bus_addr, 0);
    check({tag, "_bus_mode"}, bus_mode, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin : stim
    bit seen;
    int gd, rd, gap;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Fairness with all requesting, then a sparse pattern.
    txn(4'b1111, 0, 1, DW'($urandom), 2, 1'b0, -1);
    repeat (3) txn(4'b1111, 0, 1, DW'($urandom), 0, 1'b0, -1);
    repeat (2) txn(4'b1001, 0, 1, DW'($urandom), 0, 1'b0, -1);

    // Best-case single transaction from idle.
    txn(4'b0010, 0, 1, 8'h5C, 2, 1'b0, 'hAA);

    // Timeout, ready on terminal cycle, ready one cycle too late.
    txn(4'b0001, 0, 0, 8'h77, 1, 1'b0, -1);
    txn(4'b0100, 0, TIMEOUT, 8'h11, 0, 1'b0, -1);
    txn(4'b1000, 0, TIMEOUT + 1, 8'h22, 0, 1'b0, -1);

    // Slow slave grant while the requester drops req and changes addr/mode.
    txn(4'b0010, 10, 2, DW'($urandom), 0, 1'b1, -1);

    // Request gone by the ARB cycle: no grant at all.
    req_i = '0;
    repeat (2) begin @(posedge clk); #1; end
    req_i = 4'b0001;
    @(posedge clk); #1;
    req_i = '0;
    seen  = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (gnt_o != '0 || bus_req) seen = 1'b1;
    end
    check("pulse_no_grant", seen, 0);

    for (int n = 0; n < 40; n++) begin
      gd  = $urandom_range(0, 3);
      rd  = ($urandom_range(0, 3) != 0) ? $urandom_range(1, 3) : $urandom_range(0, TIMEOUT + 2);
      gap = (n == 0) ? 1 : $urandom_range(0, 2);
      txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), gd, rd, DW'($urandom), gap,
          1'($urandom), -1);
    end

    // Reset in the middle of WAIT aborts silently and restarts the pointer at 0.
    issue(4'b0110, 0, 0, 8'h33, 2, -1);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(posedge clk); #1;
      if (bus_start) seen = 1'b1;
    end
    check("rst_test_start_seen", seen, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    sb.delete();
    m_ptr = 0;
    req_i = '0;
    repeat (3) begin
      @(negedge clk);
      check("rst_held_done", done_o, 0);
    end
    rst_n = 1'b1;
    txn(4'b0100, 0, 1, DW'($urandom), 2, 1'b0, -1);
    txn(4'b0101, 0, 2, DW'($urandom), 0, 1'b0, -1);

    req_i = '0;
    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
